// File: rtl/axi_riscv_amo_requester.sv
// Initiator-side AMO engine: one core atomic request becomes one AXI5 atomic
// transaction (AW + single W, then B and optionally R), one transaction at a time.
module axi_riscv_amo_requester #(
    parameter int unsigned          ADDR_WIDTH = 64,
    parameter int unsigned          DATA_WIDTH = 64,
    parameter int unsigned          ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0]  AXI_ID     = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [5:0]              req_atop_i,
    input  logic [5:0]              req_xop_i,
    input  logic [2:0]              req_size_i,
    input  logic [DATA_WIDTH-1:0]   req_operand_i,

    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_data_o,
    output logic                    resp_err_o,

    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [ID_WIDTH-1:0]     aw_id_o,
    output logic [2:0]              aw_size_o,
    output logic [5:0]              aw_atop_o,
    output logic [5:0]              aw_user_o,

    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,

    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [1:0]              b_resp_i,

    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_last_i
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W    = $clog2(STRB_W);
    localparam logic [2:0]  MAX_SIZE = 3'(OFF_W);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

    function automatic logic [OFF_W-1:0] align_mask(input logic [2:0] size);
        logic [OFF_W-1:0] m;
        for (int i = 0; i < OFF_W; i++) m[i] = (i < int'(size));
        return m;
    endfunction

    function automatic logic [STRB_W-1:0] strb_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [STRB_W-1:0] s;
        for (int i = 0; i < STRB_W; i++)
            s[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] d, input logic [2:0] size);
        logic [DATA_WIDTH-1:0] o;
        logic                  sgn;
        int                    nbits;
        nbits = 8 << size;
        sgn   = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) if (i == nbits - 1) sgn = d[i];
        for (int i = 0; i < DATA_WIDTH; i++) o[i] = (i < nbits) ? d[i] : sgn;
        return o;
    endfunction

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [5:0]            aw_atop_q, aw_atop_d, aw_user_q, aw_user_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  b_ready_q, b_ready_d, r_ready_q, r_ready_d;
    logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic                  expect_r_q, expect_r_d;
    logic                  b_got_q, b_got_d, r_got_q, r_got_d;
    logic                  b_err_q, b_err_d, r_err_q, r_err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req_reject, send_done, b_hs, r_hs, b_got_n, r_got_n, wait_done;
    logic [OFF_W-1:0]      req_off;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic                  unused_inputs;

    assign req_off    = req_addr_i[OFF_W-1:0];
    assign req_reject = (req_size_i > MAX_SIZE)
                      | (|(req_off & align_mask(req_size_i)))
                      | (req_atop_i[5:4] == 2'b00)
                      | (req_atop_i == 6'b110001);
    // A channel counts as sent once its valid has been dropped or is being accepted now.
    assign send_done  = (~aw_valid_q | aw_ready_i) & (~w_valid_q | w_ready_i);
    assign b_hs       = b_valid_i & b_ready_q;
    assign r_hs       = r_valid_i & r_ready_q;
    assign b_got_n    = b_got_q | b_hs;
    assign r_got_n    = r_got_q | r_hs;
    assign wait_done  = b_got_n & (r_got_n | ~expect_r_q);
    assign rdata_n    = r_hs ? sext(r_data_i >> {off_q, 3'b000}, aw_size_q) : rdata_q;
    assign unused_inputs = ^{r_last_i, r_resp_i[0], b_resp_i[0]};

    always_ff @(posedge clk_i) begin : state_reg
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            aw_addr_q    <= '0;
            aw_size_q    <= '0;
            aw_atop_q    <= '0;
            aw_user_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            b_ready_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            off_q        <= '0;
            expect_r_q   <= 1'b0;
            b_got_q      <= 1'b0;
            r_got_q      <= 1'b0;
            b_err_q      <= 1'b0;
            r_err_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            aw_addr_q    <= aw_addr_d;
            aw_size_q    <= aw_size_d;
            aw_atop_q    <= aw_atop_d;
            aw_user_q    <= aw_user_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            b_ready_q    <= b_ready_d;
            r_ready_q    <= r_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            off_q        <= off_d;
            expect_r_q   <= expect_r_d;
            b_got_q      <= b_got_d;
            r_got_q      <= r_got_d;
            b_err_q      <= b_err_d;
            r_err_q      <= r_err_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid_i)  state_d = req_reject ? RESP : SEND;
            SEND:    if (send_done)    state_d = WAIT;
            WAIT:    if (wait_done)    state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin : output_next
        req_ready_d  = req_ready_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        aw_addr_d    = aw_addr_q;
        aw_size_d    = aw_size_q;
        aw_atop_d    = aw_atop_q;
        aw_user_d    = aw_user_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        b_ready_d    = b_ready_q;
        r_ready_d    = r_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        off_d        = off_q;
        expect_r_d   = expect_r_q;
        b_got_d      = b_got_q;
        r_got_d      = r_got_q;
        b_err_d      = b_err_q;
        r_err_d      = r_err_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            IDLE: if (req_valid_i) begin
                req_ready_d = 1'b0;
                aw_addr_d   = req_addr_i;
                aw_size_d   = req_size_i;
                aw_atop_d   = req_atop_i;
                aw_user_d   = req_xop_i;
                w_data_d    = req_operand_i << {req_off, 3'b000};
                w_strb_d    = strb_mask(req_size_i, req_off);
                off_d       = req_off;
                expect_r_d  = (req_atop_i[5:4] == 2'b10) | (req_atop_i == 6'b110000);
                b_got_d     = 1'b0;
                r_got_d     = 1'b0;
                b_err_d     = 1'b0;
                r_err_d     = 1'b0;
                rdata_d     = '0;
                if (req_reject) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                end else begin
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                end
            end
            SEND: begin
                aw_valid_d = aw_valid_q & ~aw_ready_i;
                w_valid_d  = w_valid_q & ~w_ready_i;
                if (send_done) begin
                    b_ready_d = 1'b1;
                    r_ready_d = expect_r_q;
                end
            end
            WAIT: begin
                b_got_d   = b_got_n;
                r_got_d   = r_got_n;
                b_err_d   = b_err_q | (b_hs & b_resp_i[1]);
                r_err_d   = r_err_q | (r_hs & r_resp_i[1]);
                rdata_d   = rdata_n;
                b_ready_d = ~b_got_n;
                r_ready_d = expect_r_q & ~r_got_n;
                // Any error on either channel suppresses the returned value.
                if (wait_done) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = b_err_d | r_err_d;
                    resp_data_d  = (expect_r_q && !(b_err_d || r_err_d)) ? rdata_n : '0;
                end
            end
            RESP: if (resp_ready_i) begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign aw_valid_o   = aw_valid_q;
    assign aw_addr_o    = aw_addr_q;
    assign aw_id_o      = AXI_ID;
    assign aw_size_o    = aw_size_q;
    assign aw_atop_o    = aw_atop_q;
    assign aw_user_o    = aw_user_q;
    assign w_valid_o    = w_valid_q;
    assign w_data_o     = w_data_q;
    assign w_strb_o     = w_strb_q;
    assign w_last_o     = 1'b1;
    assign b_ready_o    = b_ready_q;
    assign r_ready_o    = r_ready_q;

endmodule

// File: tb/tb_axi_riscv_amo_requester.sv
// Directed bench for axi_riscv_amo_requester (64-bit data, 64-bit address).
module tb_axi_riscv_amo_requester;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [63:0] req_addr_i;
    logic [5:0]  req_atop_i, req_xop_i;
    logic [2:0]  req_size_i;
    logic [63:0] req_operand_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [63:0] resp_data_o;
    logic        aw_valid_o, aw_ready_i;
    logic [63:0] aw_addr_o;
    logic [3:0]  aw_id_o;
    logic [2:0]  aw_size_o;
    logic [5:0]  aw_atop_o, aw_user_o;
    logic        w_valid_o, w_ready_i, w_last_o;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        r_valid_i, r_ready_o, r_last_i;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;

    int tests = 0;
    int fails = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, r_hs = 0, r_rdy_cyc = 0, axi_v_cyc = 0;
    int base_aw, base_w, base_b, base_r, base_rr, base_v;
    logic [63:0] held;

    always #5 clk = ~clk;

    axi_riscv_amo_requester dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_atop_i(req_atop_i), .req_xop_i(req_xop_i), .req_size_i(req_size_i),
        .req_operand_i(req_operand_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
        .aw_size_o(aw_size_o), .aw_atop_o(aw_atop_o), .aw_user_o(aw_user_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i)
    );

    always @(posedge clk) begin
        if (aw_valid_o && aw_ready_i) aw_hs++;
        if (w_valid_o && w_ready_i) w_hs++;
        if (b_valid_i && b_ready_o) b_hs++;
        if (r_valid_i && r_ready_o) r_hs++;
        if (r_ready_o) r_rdy_cyc++;
        if (aw_valid_o || w_valid_o) axi_v_cyc++;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [63:0] addr, input logic [2:0] size, input logic [5:0] atop,
                           input logic [5:0] xop, input logic [63:0] operand);
        req_valid_i   = 1'b1;
        req_addr_i    = addr;
        req_size_i    = size;
        req_atop_i    = atop;
        req_xop_i     = xop;
        req_operand_i = operand;
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (!resp_valid_o && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 64'(resp_valid_o), 64'h1);
    endtask

    task automatic finish_resp(input string tag);
        b_valid_i    = 1'b0;
        r_valid_i    = 1'b0;
        resp_ready_i = 1'b1;
        cyc();
        resp_ready_i = 1'b0;
        chk({tag, "_idle_valid"}, 64'(resp_valid_o), 64'h0);
        chk({tag, "_idle_ready"}, 64'(req_ready_o), 64'h1);
    endtask

    task automatic reject_case(input string tag, input logic [63:0] addr, input logic [2:0] size,
                               input logic [5:0] atop);
        base_v = axi_v_cyc;
        set_req(addr, size, atop, 6'h0, 64'h1);
        cyc();
        req_valid_i = 1'b0;
        chk({tag, "_valid"}, 64'(resp_valid_o), 64'h1);
        chk({tag, "_err"}, 64'(resp_err_o), 64'h1);
        chk({tag, "_data"}, resp_data_o, 64'h0);
        cyc();
        resp_ready_i = 1'b1;
        cyc();
        resp_ready_i = 1'b0;
        chk({tag, "_no_axi"}, 64'(axi_v_cyc - base_v), 64'h0);
        chk({tag, "_ready"}, 64'(req_ready_o), 64'h1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'h1);
        chk({tag, "_axi_valid"}, {62'h0, aw_valid_o, w_valid_o}, 64'h0);
        chk({tag, "_b_r_ready"}, {62'h0, b_ready_o, r_ready_o}, 64'h0);
        chk({tag, "_resp"}, {62'h0, resp_valid_o, resp_err_o}, 64'h0);
        chk({tag, "_resp_data"}, resp_data_o, 64'h0);
        chk({tag, "_w_last"}, 64'(w_last_o), 64'h1);
        chk({tag, "_payload"}, aw_addr_o | w_data_o | 64'(w_strb_o) | 64'(aw_atop_o)
                                | 64'(aw_size_o) | 64'(aw_user_o), 64'h0);
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; req_atop_i = '0; req_xop_i = '0;
        req_size_i = '0; req_operand_i = '0; resp_ready_i = 1'b0;
        aw_ready_i = 1'b0; w_ready_i = 1'b0;
        b_valid_i = 1'b0; b_resp_i = '0;
        r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b1;
        cyc(); cyc();
        chk_reset("rst");
        rst_ni = 1'b1;

        // AtomicLoad ADD, best-case timing
        aw_ready_i = 1'b1; w_ready_i = 1'b1;
        set_req(64'h1004, 3'd2, 6'b100000, 6'h0, 64'h5);
        cyc();
        req_valid_i = 1'b0;
        chk("ld_req_ready", 64'(req_ready_o), 64'h0);
        chk("ld_aw_w_valid", {62'h0, aw_valid_o, w_valid_o}, 64'h3);
        chk("ld_strb", 64'(w_strb_o), 64'hF0);
        chk("ld_wdata", w_data_o, 64'h5_0000_0000);
        chk("ld_aw", {aw_addr_o[31:0], 16'h0, 5'h0, aw_size_o, 2'h0, aw_atop_o}, {32'h1004, 16'h0, 5'h0, 3'd2, 2'h0, 6'h20});
        chk("ld_w_last", 64'(w_last_o), 64'h1);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        r_valid_i = 1'b1; r_resp_i = 2'b00; r_data_i = 64'h8000_0001_0000_0000;
        cyc();
        chk("ld_sent", {62'h0, aw_valid_o, w_valid_o}, 64'h0);
        chk("ld_b_r_ready", {62'h0, b_ready_o, r_ready_o}, 64'h3);
        cyc();
        chk("ld_resp_valid", 64'(resp_valid_o), 64'h1);
        chk("ld_resp_data", resp_data_o, 64'hFFFF_FFFF_8000_0001);
        chk("ld_resp_err", 64'(resp_err_o), 64'h0);
        chk("ld_readies_drop", {62'h0, b_ready_o, r_ready_o}, 64'h0);
        finish_resp("ld");

        // AtomicStore: B only, stray R left unacknowledged
        base_rr = r_rdy_cyc; base_r = r_hs;
        set_req(64'h2000, 3'd3, 6'b010000, 6'h0, 64'h1122_3344_5566_7788);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        r_valid_i = 1'b1; r_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc();
        req_valid_i = 1'b0;
        chk("st_strb", 64'(w_strb_o), 64'hFF);
        chk("st_wdata", w_data_o, 64'h1122_3344_5566_7788);
        cyc();
        chk("st_b_ready", 64'(b_ready_o), 64'h1);
        cyc();
        chk("st_resp_valid", 64'(resp_valid_o), 64'h1);
        chk("st_resp", {resp_data_o[62:0], resp_err_o}, 64'h0);
        finish_resp("st");
        chk("st_no_r_ready", 64'(r_rdy_cyc - base_rr), 64'h0);
        chk("st_no_r_hs", 64'(r_hs - base_r), 64'h0);

        // Skewed handshakes: AW late, W immediate, R before B
        base_aw = aw_hs; base_w = w_hs; base_b = b_hs; base_r = r_hs;
        aw_ready_i = 1'b0; w_ready_i = 1'b1;
        set_req(64'h3008, 3'd3, 6'b100000, 6'h0, 64'h1);
        cyc();
        req_valid_i = 1'b0;
        chk("sk_both_valid", {62'h0, aw_valid_o, w_valid_o}, 64'h3);
        cyc();
        chk("sk_w_done", {62'h0, aw_valid_o, w_valid_o}, 64'h2);
        cyc();
        chk("sk_aw_held", {62'h0, aw_valid_o, b_ready_o}, 64'h2);
        cyc();
        aw_ready_i = 1'b1;
        cyc();
        chk("sk_wait", {61'h0, aw_valid_o, b_ready_o, r_ready_o}, 64'h3);
        r_valid_i = 1'b1; r_resp_i = 2'b00; r_data_i = 64'h0123_4567_89AB_CDEF;
        cyc();
        chk("sk_r_taken", {61'h0, resp_valid_o, b_ready_o, r_ready_o}, 64'h2);
        r_valid_i = 1'b0; b_valid_i = 1'b1; b_resp_i = 2'b00;
        cyc();
        chk("sk_resp_valid", 64'(resp_valid_o), 64'h1);
        chk("sk_resp_data", resp_data_o, 64'h0123_4567_89AB_CDEF);
        chk("sk_resp_err", 64'(resp_err_o), 64'h0);
        finish_resp("sk");
        chk("sk_hs_counts", {32'(aw_hs - base_aw), 32'(w_hs - base_w)}, {32'd1, 32'd1});
        chk("sk_b_r_counts", {32'(b_hs - base_b), 32'(r_hs - base_r)}, {32'd1, 32'd1});

        // Rejected requests
        reject_case("rej_misalign", 64'h1004, 3'd3, 6'b100000);
        reject_case("rej_size", 64'h1000, 3'd4, 6'b100000);
        reject_case("rej_nonatomic", 64'h1000, 3'd3, 6'b000000);
        reject_case("rej_compare", 64'h1000, 3'd3, 6'b110001);

        // Swap with SLVERR on B
        base_r = r_hs;
        aw_ready_i = 1'b1; w_ready_i = 1'b1;
        set_req(64'h4000, 3'd3, 6'b110000, 6'h0, 64'h9);
        b_valid_i = 1'b1; b_resp_i = 2'b10;
        r_valid_i = 1'b1; r_resp_i = 2'b00; r_data_i = 64'hDEAD;
        cyc();
        req_valid_i = 1'b0;
        wait_resp("sw_resp_valid");
        chk("sw_err", 64'(resp_err_o), 64'h1);
        chk("sw_data", resp_data_o, 64'h0);
        chk("sw_r_taken", 64'(r_hs - base_r), 64'h1);
        b_resp_i = 2'b00;
        finish_resp("sw");

        // Extended op with response backpressure
        set_req(64'h5003, 3'd0, 6'b100000, 6'h05, 64'h1);
        cyc();
        req_valid_i = 1'b0;
        chk("xop_user", 64'(aw_user_o), 64'h05);
        chk("xop_strb", 64'(w_strb_o), 64'h08);
        chk("xop_wdata", w_data_o, 64'h0100_0000);
        b_valid_i = 1'b1; r_valid_i = 1'b1; r_data_i = 64'h8000_0000;
        wait_resp("xop_resp_valid");
        chk("xop_data", resp_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        held = resp_data_o;
        b_valid_i = 1'b0; r_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold", {61'h0, resp_valid_o, req_ready_o, resp_err_o}, 64'h4);
            chk("bp_data", resp_data_o, held);
        end
        finish_resp("xop");

        // Reset during WAIT, then a fresh transaction
        set_req(64'h6000, 3'd3, 6'b100000, 6'h0, 64'h77);
        cyc();
        req_valid_i = 1'b0;
        cyc();
        chk("mid_wait", 64'(b_ready_o), 64'h1);
        rst_ni = 1'b0;
        cyc();
        chk_reset("mid_rst");
        rst_ni = 1'b1;
        set_req(64'h6008, 3'd2, 6'b010000, 6'h0, 64'hAB);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        cyc();
        req_valid_i = 1'b0;
        chk("post_strb", 64'(w_strb_o), 64'h0F);
        chk("post_wdata", w_data_o, 64'hAB);
        wait_resp("post_resp_valid");
        chk("post_resp", {resp_data_o[62:0], resp_err_o}, 64'h0);
        finish_resp("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_riscv_amo_requester.md
# axi_riscv_amo_requester

Initiator-side engine that turns a single core AMO request into one AXI5 atomic transaction: an AW beat carrying `atop` and the extended-op code, one W beat, then collection of B and, for value-returning atomics, R. It sits between the cache/LSU AMO port and the AXI master port, and is the issuing end of the transactions that the memory-side atomics adapter resolves. It allows one transaction in flight at a time.

## Interface
- `ADDR_WIDTH`, default 64: AXI address width.
- `DATA_WIDTH`, default 64: AXI data width; a power of two, at least 32.
- `ID_WIDTH`, default 4: AXI ID width.
- `AXI_ID`, default '0: constant ID driven on `aw_id_o`.
- `clk_i` input 1: clock; the only clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `req_valid_i` / `req_ready_o` input/output 1: request handshake.
- `req_addr_i` input ADDR_WIDTH: byte address.
- `req_atop_i` input 6: AXI `atop` encoding.
- `req_xop_i` input 6: extended AMO code; 0 means none.
- `req_size_i` input 3: log2 of the byte count.
- `req_operand_i` input DATA_WIDTH: operand, LSB-aligned.
- `resp_valid_o` / `resp_ready_i` output/input 1: response handshake.
- `resp_data_o` output DATA_WIDTH: old memory value, sign-extended from the access size.
- `resp_err_o` output 1: error flag.
- `aw_valid_o`, `aw_ready_i`, `aw_addr_o`, `aw_id_o`, `aw_size_o` [2:0], `aw_atop_o` [5:0], `aw_user_o` [5:0] (carries the xop): AW channel.
- `w_valid_o`, `w_ready_i`, `w_data_o`, `w_strb_o` [DATA_WIDTH/8], `w_last_o`: W channel.
- `b_valid_i`, `b_ready_o`, `b_resp_i` [1:0]: B channel.
- `r_valid_i`, `r_ready_o`, `r_data_i`, `r_resp_i` [1:0], `r_last_i`: R channel.

## Operation
- **States:** IDLE, SEND, WAIT, RESP.
- **Request acceptance:** `req_ready_o` is 1 only in IDLE. On `req_valid_i & req_ready_o`, all request fields are registered.
- **Rejected requests.** The request skips the bus and goes straight to RESP with `resp_err_o`=1 and `resp_data_o`=0 if any of these holds:
  - `req_size_i` is greater than log2(DATA_WIDTH/8).
  - The address is misaligned to the size.
  - `req_atop_i`[5:4] is 00 (not an atomic).
  - `req_atop_i` is 6'b110001 (compare).
- **Otherwise go to SEND.**
  - Byte offset `off` = addr[log2(DATA_WIDTH/8)-1:0].
  - `w_data_o` = operand << (8·off).
  - `w_strb_o` = ((1 << 2^size) − 1) << off.
  - `w_last_o` = 1.
  - `aw_addr_o` = addr, `aw_size_o` = size, `aw_atop_o` = atop, `aw_user_o` = xop.
- **SEND:** `aw_valid_o` and `w_valid_o` assert together. Each drops independently after its own handshake, tracked by sent flags. The block goes to WAIT once both flags are set, including when both handshakes complete in the same cycle.
- **Response expectation:**
  - R is expected when atop[5:4] = 10 (AtomicLoad) or atop = 6'b110000 (swap).
  - AtomicStore (01) expects B only.
- **WAIT:**
  - `b_ready_o` = 1 until B is received.
  - `r_ready_o` = 1 until R is received, and only when R is expected.
  - B and R may arrive in either order or in the same cycle. Each is latched once.
  - The block goes to RESP when every expected channel has been received.
  - An unexpected `r_valid_i` is left unacknowledged.
- **Response values:**
  - `resp_err_o` = `b_resp_i`[1] OR `r_resp_i`[1].
  - `resp_data_o` = sign-extend((`r_data_i` >> 8·off), bits 8·2^size), provided R was expected and had no error. Otherwise it is 0.
- **RESP:** `resp_valid_o` = 1 and is held with stable data until `resp_ready_i`; then the block returns to IDLE.
- **Reset:** in any state, reset returns the block to IDLE immediately. There is no draining of outstanding AXI beats.

## Timing
- **Reset values:**
  - `req_ready_o` = 1.
  - All AXI valids = 0; `b_ready_o` = 0, `r_ready_o` = 0.
  - `resp_valid_o` = 0, `resp_data_o` = 0, `resp_err_o` = 0.
  - `w_last_o` = 1; the other AXI payload outputs are 0.
- **Registered outputs:** all outputs come from flops. There are no combinational paths from input to output.
- **Cycle-by-cycle, with the request accepted at cycle t:**
  - t+1: AW and W valid.
  - If both are accepted at t+1 and B/R are valid at t+2, they are accepted at t+2.
  - `resp_valid_o` rises at t+3.
  - Best-case latency from accept to response is 3 cycles.
- **Rejected requests:** `resp_valid_o` at t+1.
- **Back-to-back requests:** after the response handshake at cycle u, `req_ready_o` = 1 at u+1.
- **Valid stability:** AXI valids never drop before their ready; payloads stay stable while valid.

## Test plan
- **AtomicLoad ADD:** DATA_WIDTH=64, addr 0x1004, size 2, atop 6'b100000, operand 0x5. Required: `w_strb_o` = 0xF0 and `w_data_o` = 0x5_0000_0000. Respond with R data 0x8000_0001_0000_0000, OKAY. Required: `resp_data_o` = 0xFFFF_FFFF_8000_0001, `resp_err_o` = 0.
- **AtomicStore:** atop 6'b010000. Required: `r_ready_o` never asserts; B OKAY → response with data 0, err 0.
- **Skewed handshakes:** `aw_ready_i` delayed 3 cycles, `w_ready_i` immediate, R arriving before B. Required: exactly one AW and one W handshake, one response, and the block returns to IDLE.
- **Errors:**
  - Misaligned size-3 request at 0x1004 → `resp_err_o` = 1 at t+1, with no AXI valid ever asserted.
  - Swap with `b_resp_i` = SLVERR → `resp_err_o` = 1, `resp_data_o` = 0.
- **Extended op and response backpressure:** xop INC. Required: `aw_user_o` equals the xop code. Hold `resp_ready_i` low 5 cycles. Required: `resp_valid_o` and its data stay stable and `req_ready_o` stays 0 throughout.
- **Reset mid-transaction:** `rst_ni` low during WAIT. Required: the next cycle shows the reset values, and a new request completes normally afterwards.
